// File: rtl/sdr_wb_pkg.sv
// Shared types and constants for the Wishbone burst master feeding the SDRAM controller.
// Holds the control FSM state encoding, the Wishbone cycle-type codes and default bus widths.
// Also provides the burst-length helper used when a command is accepted.
package sdr_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUS    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int DEF_DW = 32;
  localparam int DEF_AW = 26;

  // A zero beat count means a single beat.
  function automatic logic [7:0] eff_beats(input logic [7:0] bl);
    return (bl == 8'd0) ? 8'd1 : bl;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Stall watchdog: counts cycles while enabled, flags expiry when the count sits at TIMEOUT-1.
// Latency: expire is combinational from the count and enable; count updates each clock.
// No backpressure; clear has priority over counting.
module wb_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up while enabled and stop at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone burst master: turns word-addressed read/write burst commands into incrementing Wishbone cycles.
// Latency: strobe one cycle after command accept; done two cycles after the final ack (reads).
// Backpressure: cmd_ready only in IDLE; wdat_ready only when no beat is pending on the bus or it is being acked.
module wb_burst_master
  import sdr_wb_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int AW      = DEF_AW,
  parameter int TIMEOUT = 1024
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [7:0]      cmd_bl,
  input  logic            wdat_valid,
  output logic            wdat_ready,
  input  logic [DW-1:0]   wdat,
  output logic            rdat_valid,
  output logic [DW-1:0]   rdat,
  output logic            done,
  output logic            err,
  output logic            wb_stb_i,
  output logic            wb_cyc_i,
  output logic            wb_we_i,
  output logic [AW-1:0]   wb_addr_i,
  output logic [DW-1:0]   wb_dat_i,
  output logic [DW/8-1:0] wb_sel_i,
  output logic [2:0]      wb_cti_i,
  input  logic            wb_ack_o,
  input  logic [DW-1:0]   wb_dat_o
);

  localparam int SW = DW / 8;

  state_e          state_q, state_d;
  logic            cyc_q, cyc_d;
  logic            stb_q, stb_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [2:0]      cti_q, cti_d;
  logic [DW-1:0]   rdat_q, rdat_d;
  logic            rdat_vld_q, rdat_vld_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [7:0]      rem_q, rem_d;       // beats still to be acked
  logic [7:0]      ld_rem_q, ld_rem_d; // write beats still to be loaded
  logic            single_q, single_d; // burst is one beat long (classic cycle)
  logic            abort_q, abort_d;   // FINISH was reached through the watchdog

  logic            cmd_hs;
  logic            wdat_hs;
  logic            ack_beat;
  logic            last_beat;
  logic            wd_clr;
  logic            wd_expire;
  logic            abort;
  logic [7:0]      cmd_beats;

  assign cmd_ready  = (state_q == ST_IDLE);
  assign cmd_hs     = cmd_valid && cmd_ready;
  assign wdat_ready = (state_q == ST_BUS) && we_q && (ld_rem_q != 8'd0) && (!stb_q || wb_ack_o);
  assign wdat_hs    = wdat_valid && wdat_ready;
  // An ack only counts while a beat is actually being strobed.
  assign ack_beat   = stb_q && wb_ack_o;
  assign last_beat  = (rem_q == 8'd1);
  assign cmd_beats  = eff_beats(cmd_bl);

  // The watchdog only runs against a strobed beat; an ack in the expiry cycle still completes it.
  assign wd_clr = (state_q != ST_BUS) || wb_ack_o;
  assign abort  = wd_expire && !wb_ack_o;

  wb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_i (wb_clk_i),
    .rst_i (wb_rst_i),
    .clr   (wd_clr),
    .en    (stb_q),
    .expire(wd_expire)
  );

  // Next-state and next-output logic for the burst FSM.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    addr_d     = addr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    cti_d      = cti_q;
    rdat_d     = rdat_q;
    rdat_vld_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rem_d      = rem_q;
    ld_rem_d   = ld_rem_q;
    single_d   = single_q;
    abort_d    = abort_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_hs) begin
          state_d  = ST_BUS;
          we_d     = cmd_we;
          addr_d   = cmd_addr;
          rem_d    = cmd_beats;
          ld_rem_d = cmd_we ? cmd_beats : 8'd0;
          single_d = (cmd_beats == 8'd1);
          abort_d  = 1'b0;
          cyc_d    = 1'b1;
          // Reads strobe immediately; writes wait for their first data beat.
          if (!cmd_we) begin
            stb_d = 1'b1;
            sel_d = {SW{1'b1}};
            cti_d = (cmd_beats == 8'd1) ? CTI_CLASSIC : CTI_INCR;
          end
        end
      end

      ST_BUS: begin
        if (ack_beat) begin
          rem_d = rem_q - 8'd1;
          if (!we_q) begin
            rdat_d     = wb_dat_o;
            rdat_vld_d = 1'b1;
          end
          if (last_beat) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            sel_d   = '0;
            state_d = ST_FINISH;
          end else begin
            addr_d = addr_q + 1'b1;
            if (!we_q) begin
              cti_d = (rem_q == 8'd2) ? CTI_EOB : CTI_INCR;
            end else begin
              // Write wait state unless a new beat is loaded below in this same cycle.
              stb_d = 1'b0;
              sel_d = '0;
            end
          end
        end else if (abort) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          sel_d   = '0;
          abort_d = 1'b1;
          state_d = ST_FINISH;
        end

        // Loading a write beat (re)asserts the strobe with the matching cycle type.
        if (wdat_hs) begin
          dat_d    = wdat;
          stb_d    = 1'b1;
          sel_d    = {SW{1'b1}};
          ld_rem_d = ld_rem_q - 8'd1;
          if (single_q) begin
            cti_d = CTI_CLASSIC;
          end else begin
            cti_d = (ld_rem_q == 8'd1) ? CTI_EOB : CTI_INCR;
          end
        end
      end

      ST_FINISH: begin
        done_d  = 1'b1;
        err_d   = abort_q;
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Burst FSM state and all registered bus/user outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      cti_q      <= CTI_CLASSIC;
      rdat_q     <= '0;
      rdat_vld_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rem_q      <= 8'd0;
      ld_rem_q   <= 8'd0;
      single_q   <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      cti_q      <= cti_d;
      rdat_q     <= rdat_d;
      rdat_vld_q <= rdat_vld_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rem_q      <= rem_d;
      ld_rem_q   <= ld_rem_d;
      single_q   <= single_d;
      abort_q    <= abort_d;
    end
  end

  assign wb_cyc_i   = cyc_q;
  assign wb_stb_i   = stb_q;
  assign wb_we_i    = we_q;
  assign wb_addr_i  = addr_q;
  assign wb_dat_i   = dat_q;
  assign wb_sel_i   = sel_q;
  assign wb_cti_i   = cti_q;
  assign rdat       = rdat_q;
  assign rdat_valid = rdat_vld_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: a table of burst vectors driven through a cycle-accurate slave/source model.
// Each vector carries its own hand-computed beat count, done cycle, error flag and wait-state counts.
// Hand-written sequences cover reset state and reset asserted in the middle of a burst.
module tb_wb_burst_master;

  localparam int DW = 32;
  localparam int AW = 26;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0]   cmd_addr;
  logic [7:0]      cmd_bl;
  logic            wdat_valid, wdat_ready;
  logic [DW-1:0]   wdat;
  logic            rdat_valid;
  logic [DW-1:0]   rdat;
  logic            done, err;
  logic            wb_stb_i, wb_cyc_i, wb_we_i;
  logic [AW-1:0]   wb_addr_i;
  logic [DW-1:0]   wb_dat_i;
  logic [DW/8-1:0] wb_sel_i;
  logic [2:0]      wb_cti_i;
  logic            wb_ack_o;
  logic [DW-1:0]   wb_dat_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_burst_master #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_bl    (cmd_bl),
    .wdat_valid(wdat_valid),
    .wdat_ready(wdat_ready),
    .wdat      (wdat),
    .rdat_valid(rdat_valid),
    .rdat      (rdat),
    .done      (done),
    .err       (err),
    .wb_stb_i  (wb_stb_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_we_i   (wb_we_i),
    .wb_addr_i (wb_addr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_sel_i  (wb_sel_i),
    .wb_cti_i  (wb_cti_i),
    .wb_ack_o  (wb_ack_o),
    .wb_dat_o  (wb_dat_o)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    bl;
    int            wait_n;    // slave wait cycles per beat, -1 = random 0..3
    logic          never;     // slave never acks
    int            gap_beat;  // write beat index preceded by a valid gap, -1 = none
    int            gap_len;
    logic          stray;     // slave acks while stb is low
    logic [DW-1:0] base;      // data of beat 0; beat i carries base+i
    int            exp_beats;
    int            exp_done;  // cycle of done after the handshake cycle, -1 = not fixed
    logic          exp_err;
    int            exp_waits; // cycles with cyc=1 and stb=0, -1 = not checked
    int            exp_stb;   // cycles with stb=1, -1 = not checked
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n, ld, gapcnt, wcnt, curwait, beat, rd_idx;
    int done_cyc, done_cnt, err_viol, waits, stbc, rdy_viol, cr_viol, extra;
    logic [AW-1:0] ea;
    logic [2:0]    ecti;
    n = (v.bl == 8'd0) ? 1 : int'(v.bl);
    ld = 0; gapcnt = 0; wcnt = 0; beat = 0; rd_idx = 0;
    done_cyc = -1; done_cnt = 0; err_viol = 0; waits = 0; stbc = 0;
    rdy_viol = 0; cr_viol = 0; extra = 0;
    curwait = (v.wait_n < 0) ? int'($urandom_range(0, 3)) : v.wait_n;

    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = v.we; cmd_addr = v.addr; cmd_bl = v.bl;
    @(negedge clk);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;

    for (int c = 1; c < 200; c++) begin
      // Offer a competing command while the bus is busy; it must not be taken.
      cmd_valid = wb_cyc_i;
      wb_ack_o  = 1'b0;
      if (wb_stb_i) begin
        if (!v.never && wcnt == curwait) begin
          wb_ack_o = 1'b1;
          wb_dat_o = v.base + DW'(beat);
          wcnt = 0;
          curwait = (v.wait_n < 0) ? int'($urandom_range(0, 3)) : v.wait_n;
        end else begin
          wcnt++;
        end
      end else if (v.stray && wb_cyc_i) begin
        wb_ack_o = 1'b1;
      end
      wdat_valid = 1'b0;
      if (v.we && ld < n) begin
        if (ld == v.gap_beat && gapcnt < v.gap_len) begin
          gapcnt++;
        end else begin
          wdat_valid = 1'b1;
          wdat = v.base + DW'(ld);
        end
      end

      @(negedge clk);
      if (wb_stb_i) stbc++;
      if (wb_cyc_i && !wb_stb_i) waits++;
      if (cmd_ready && !done) cr_viol++;
      if (wdat_ready && (!v.we || ld >= n)) rdy_viol++;
      if (err != (done && v.exp_err)) err_viol++;
      if (wb_stb_i && wb_ack_o) begin
        ea   = v.addr + AW'(beat);
        ecti = (n == 1) ? 3'b000 : ((beat == n - 1) ? 3'b111 : 3'b010);
        chk({tag, "_addr"}, 64'(wb_addr_i), 64'(ea));
        chk({tag, "_cti"}, 64'(wb_cti_i), 64'(ecti));
        chk({tag, "_sel"}, 64'(wb_sel_i), 64'hF);
        chk({tag, "_we"}, 64'(wb_we_i), 64'(v.we));
        if (v.we) chk({tag, "_wdat"}, 64'(wb_dat_i), 64'(v.base + DW'(beat)));
        beat++;
      end
      if (wdat_valid && wdat_ready) ld++;
      if (rdat_valid) begin
        chk({tag, "_rdat"}, 64'(rdat), 64'(v.base + DW'(rd_idx)));
        rd_idx++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end

    cmd_valid = 1'b0; wb_ack_o = 1'b0; wdat_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (done || rdat_valid || wb_cyc_i || err) extra++;
    end

    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, "_beats"}, 64'(beat), 64'(v.exp_beats));
    chk({tag, "_rdat_cnt"}, 64'(rd_idx), v.we ? 64'd0 : 64'(v.exp_beats));
    chk({tag, "_err"}, 64'(err_viol), 64'd0);
    chk({tag, "_cmd_rdy_busy"}, 64'(cr_viol), 64'd0);
    chk({tag, "_wdat_rdy"}, 64'(rdy_viol), 64'd0);
    chk({tag, "_after_done"}, 64'(extra), 64'd0);
    if (v.exp_done >= 0) chk({tag, "_done_cyc"}, 64'(done_cyc), 64'(v.exp_done));
    if (v.exp_waits >= 0) chk({tag, "_waits"}, 64'(waits), 64'(v.exp_waits));
    if (v.exp_stb >= 0) chk({tag, "_stb_cyc"}, 64'(stbc), 64'(v.exp_stb));
  endtask

  initial begin
    //           we    addr          bl     wait nev   gapb gapl stray base            beats done err   waits stb
    tbl[0] = '{1'b0, 26'h0000100, 8'd1,  2,  1'b0, -1,  0,  1'b0, 32'hDEADBEEF,  1,   5,   1'b0, -1,   3};
    tbl[1] = '{1'b1, 26'h3FFFFFE, 8'd4,  0,  1'b0, -1,  0,  1'b0, 32'h00000001,  4,   7,   1'b0, -1,  -1};
    tbl[2] = '{1'b1, 26'h0000020, 8'd3,  0,  1'b0,  1,  3,  1'b1, 32'h00000100,  3,   9,   1'b0,  4,  -1};
    tbl[3] = '{1'b0, 26'h0000040, 8'd8, -1,  1'b0, -1,  0,  1'b0, 32'h00005000,  8,  -1,   1'b0, -1,  -1};
    tbl[4] = '{1'b0, 26'h3FFFFFF, 8'd0,  0,  1'b0, -1,  0,  1'b0, 32'h00000077,  1,   3,   1'b0, -1,  -1};
    tbl[5] = '{1'b1, 26'h0000010, 8'd1,  0,  1'b0, -1,  0,  1'b0, 32'h00000055,  1,   4,   1'b0, -1,  -1};
    tbl[6] = '{1'b0, 26'h3FFFFFF, 8'd2,  0,  1'b0, -1,  0,  1'b0, 32'h00000900,  2,   4,   1'b0, -1,  -1};
    tbl[7] = '{1'b0, 26'h0000080, 8'd4,  0,  1'b1, -1,  0,  1'b0, 32'h00000000,  0,  18,   1'b1, -1,  16};
    tbl[8] = '{1'b1, 26'h0000090, 8'd2,  0,  1'b1, -1,  0,  1'b0, 32'hA5A50000,  0,  19,   1'b1, -1,  16};
    tbl[9] = '{1'b0, 26'h00000A0, 8'd1, 15,  1'b0, -1,  0,  1'b0, 32'hCAFE0000,  1,  18,   1'b0, -1,  16};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_bl = 8'd0;
    wdat_valid = 1'b0; wdat = '0; wb_ack_o = 1'b0; wb_dat_o = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", 64'(wb_cyc_i), 64'd0);
    chk("rst_stb", 64'(wb_stb_i), 64'd0);
    chk("rst_sel", 64'(wb_sel_i), 64'd0);
    chk("rst_done_err", 64'({done, err, rdat_valid, wdat_ready}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 10; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset asserted in the middle of a 4-beat read, while beat 2 is being acked.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 26'h0000200; cmd_bl = 8'd4;
    @(posedge clk); #1;
    cmd_valid = 1'b0; wb_ack_o = 1'b1; wb_dat_o = 32'h12345678;
    @(negedge clk);
    chk("mid_stb", 64'(wb_stb_i), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rvld", 64'(rdat_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    wb_ack_o = 1'b0;
    chk("mid_rst_cyc_stb", 64'({wb_cyc_i, wb_stb_i}), 64'd0);
    chk("mid_rst_we_sel_cti", 64'({wb_we_i, wb_sel_i, wb_cti_i}), 64'd0);
    chk("mid_rst_addr", 64'(wb_addr_i), 64'd0);
    chk("mid_rst_wdat", 64'(wb_dat_i), 64'd0);
    chk("mid_rst_rdat", 64'(rdat), 64'd0);
    chk("mid_rst_flags", 64'({rdat_valid, done, err, wdat_ready}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      int stray_evt;
      stray_evt = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (done || err || rdat_valid || wb_cyc_i || !cmd_ready) stray_evt++;
        @(posedge clk); #1;
      end
      chk("post_rst_quiet", 64'(stray_evt), 64'd0);
    end
    run_vec(tbl[0], "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
